// File: rtl/fpgc_bus_pkg.sv
// Shared types for the two-port memory-bus arbiter.
// Holds the FSM state enum, the timeout read value and port indices.
package fpgc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } arb_state_e;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/bus_arb_port.sv
// Per-requester latch: captures a request, holds pending, keeps read data.
// Ports: addr/data/we/start from requester; clr/load from the FSM; latched outputs.
module bus_arb_port
  import fpgc_bus_pkg::*;
#(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              we_i,
  input  logic              start_i,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic              pending_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              we_o,
  output logic [DATA_W-1:0] q_o
);

  logic              accept;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              we_q;
  logic [DATA_W-1:0] q_q, q_d;

  // a start while pending (incl. the done cycle) is dropped
  assign accept = start_i && !pend_q;

  always_comb begin
    pend_d = pend_q;
    if (clr_i) begin
      pend_d = 1'b0;
    end else if (accept) begin
      pend_d = 1'b1;
    end
    q_d = load_i ? load_data_i : q_q;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pend_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
      q_q    <= '0;
    end else begin
      pend_q <= pend_d;
      q_q    <= q_d;
      if (accept) begin
        addr_q <= addr_i;
        data_q <= data_i;
        we_q   <= we_i;
      end
    end
  end

  assign pending_o = pend_q;
  assign addr_o    = addr_q;
  assign data_o    = data_q;
  assign we_o      = we_q;
  assign q_o       = q_q;

endmodule

// File: rtl/bus_arbiter.sv
// Two-port (CPU/DMA) arbiter onto a single MemoryUnit bus with timeout.
// Ports: s0_*/s1_* requesters, m_* memory bus, timeout_err pulse.
module bus_arbiter
  import fpgc_bus_pkg::*;
#(
  parameter int ADDR_W     = 27,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [ADDR_W-1:0] s0_addr,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s0_we,
  input  logic              s0_start,
  output logic [DATA_W-1:0] s0_q,
  output logic              s0_done,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s1_we,
  input  logic              s1_start,
  output logic [DATA_W-1:0] s1_q,
  output logic              s1_done,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_data,
  output logic              m_we,
  output logic              m_start,
  input  logic [DATA_W-1:0] m_q,
  input  logic              m_done,
  output logic              timeout_err
);

  localparam int CNT_W =
    (TIMEOUT > 1023) ? $clog2(TIMEOUT + 1) : 10;

  arb_state_e        state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              terr_q, terr_d;

  logic              pend0, pend1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] data0, data1;
  logic              we0, we1;
  logic              clr0, clr1;
  logic              ld0, ld1;
  logic [DATA_W-1:0] ld_data;
  logic              pick;

  bus_arb_port #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_p0 (
    .clk        (clk),
    .nreset     (nreset),
    .addr_i     (s0_addr),
    .data_i     (s0_data),
    .we_i       (s0_we),
    .start_i    (s0_start),
    .clr_i      (clr0),
    .load_i     (ld0),
    .load_data_i(ld_data),
    .pending_o  (pend0),
    .addr_o     (addr0),
    .data_o     (data0),
    .we_o       (we0),
    .q_o        (s0_q)
  );

  bus_arb_port #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_p1 (
    .clk        (clk),
    .nreset     (nreset),
    .addr_i     (s1_addr),
    .data_i     (s1_data),
    .we_i       (s1_we),
    .start_i    (s1_start),
    .clr_i      (clr1),
    .load_i     (ld1),
    .load_data_i(ld_data),
    .pending_o  (pend1),
    .addr_o     (addr1),
    .data_o     (data1),
    .we_o       (we1),
    .q_o        (s1_q)
  );

  // tie: fixed mode favours CPU, else the port not served last
  always_comb begin
    pick = PORT_CPU;
    unique case (1'b1)
      (pend0 && pend1):
        pick = (FIXED_PRIO != 0) ? PORT_CPU : ~last_q;
      (pend1 && !pend0):
        pick = PORT_DMA;
      default:
        pick = PORT_CPU;
    endcase
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    terr_d  = 1'b0;
    ld0     = 1'b0;
    ld1     = 1'b0;
    clr0    = 1'b0;
    clr1    = 1'b0;
    ld_data = m_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pend0 || pend1) begin
          grant_d = pick;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (m_done) begin
          ld0     = (grant_q == PORT_CPU);
          ld1     = (grant_q == PORT_DMA);
          state_d = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // TIMEOUT-th wait cycle with no reply
          ld0     = (grant_q == PORT_CPU);
          ld1     = (grant_q == PORT_DMA);
          ld_data = DATA_W'(TIMEOUT_DATA);
          terr_d  = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        clr0    = (grant_q == PORT_CPU);
        clr1    = (grant_q == PORT_DMA);
        last_d  = grant_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      grant_q <= PORT_CPU;
      last_q  <= PORT_DMA;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

  // granted latch is frozen while pending, so the bus is stable
  assign m_addr  = grant_q ? addr1 : addr0;
  assign m_data  = grant_q ? data1 : data0;
  assign m_we    = grant_q ? we1 : we0;
  assign m_start = (state_q == ST_ISSUE);

  assign s0_done = (state_q == ST_RESP) && (grant_q == PORT_CPU);
  assign s1_done = (state_q == ST_RESP) && (grant_q == PORT_DMA);

  assign timeout_err = terr_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: round-robin and fixed-priority copies side by side.
// Transaction-level reference model predicts issue/done timing and data.
module tb_bus_arbiter;

  localparam int AW  = 27;
  localparam int DW  = 32;
  localparam int TMO = 16;

  typedef struct {
    int            cyc;
    int            port;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          we;
  } req_t;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          we;
  } iss_t;

  typedef struct {
    int            cyc;
    int            port;
    logic [DW-1:0] q;
    logic          terr;
  } done_t;

  logic clk = 1'b0;
  logic nreset = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] s0_addr = '0, s1_addr = '0;
  logic [DW-1:0] s0_data = '0, s1_data = '0;
  logic          s0_we = 1'b0, s1_we = 1'b0;
  logic          s0_start = 1'b0, s1_start = 1'b0;

  logic [DW-1:0] s0q [2];
  logic [DW-1:0] s1q [2];
  logic          s0done [2];
  logic          s1done [2];
  logic [AW-1:0] maddr [2];
  logic [DW-1:0] mdata [2];
  logic          mwe [2];
  logic          mstart [2];
  logic [DW-1:0] mq [2] = '{32'h0, 32'h0};
  logic          mdone [2] = '{1'b0, 1'b0};
  logic          terr [2];

  for (genvar g = 0; g < 2; g++) begin : gd
    bus_arbiter #(
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .FIXED_PRIO(g),
      .TIMEOUT   (TMO)
    ) u_dut (
      .clk        (clk),
      .nreset     (nreset),
      .s0_addr    (s0_addr),
      .s0_data    (s0_data),
      .s0_we      (s0_we),
      .s0_start   (s0_start),
      .s0_q       (s0q[g]),
      .s0_done    (s0done[g]),
      .s1_addr    (s1_addr),
      .s1_data    (s1_data),
      .s1_we      (s1_we),
      .s1_start   (s1_start),
      .s1_q       (s1q[g]),
      .s1_done    (s1done[g]),
      .m_addr     (maddr[g]),
      .m_data     (mdata[g]),
      .m_we       (mwe[g]),
      .m_start    (mstart[g]),
      .m_q        (mq[g]),
      .m_done     (mdone[g]),
      .timeout_err(terr[g])
    );
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  req_t  plan [$];
  iss_t  exp_iss [2][$];
  iss_t  act_iss [2][$];
  done_t exp_done [2][$];
  done_t act_done [2][$];
  int    exp_terr [2] = '{0, 0};
  int    terr_cnt [2] = '{0, 0};
  int    stab_err [2] = '{0, 0};
  int    mlast [2] = '{1, 1};
  logic [DW-1:0] mq_last [2][2];
  int    endc;

  // memory behaviour: latency and read data follow from the address
  function automatic int lat_of(logic [AW-1:0] a);
    return a[AW-1] ? TMO + 3 : 3 + int'(a[2:0]);
  endfunction

  function automatic logic [DW-1:0] rd_of(logic [AW-1:0] a);
    return (a == 27'h100) ? 32'h12345678 : {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [DW-1:0] sq_of(int g, int p);
    return (p == 0) ? s0q[g] : s1q[g];
  endfunction

  int            rcnt [2] = '{0, 0};
  logic [AW-1:0] raddr [2];

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      mdone[g] = 1'b0;
      if (rcnt[g] > 0) begin
        rcnt[g]--;
        if (rcnt[g] == 0) begin
          mdone[g] = 1'b1;
          mq[g]    = rd_of(raddr[g]);
        end
      end
      if (mstart[g]) begin
        rcnt[g]  = lat_of(maddr[g]);
        raddr[g] = maddr[g];
      end
    end
  end

  logic [59:0] hold [2];
  bit          busy [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!nreset) busy[g] = 1'b0;
      if (mstart[g]) begin
        act_iss[g].push_back(iss_t'{cyc, maddr[g], mdata[g], mwe[g]});
        hold[g] = {maddr[g], mdata[g], mwe[g]};
        busy[g] = 1'b1;
      end else if (busy[g] && hold[g] !== {maddr[g], mdata[g], mwe[g]}) begin
        stab_err[g]++;
      end
      if (s0done[g]) begin
        act_done[g].push_back(done_t'{cyc, 0, s0q[g], terr[g]});
        busy[g] = 1'b0;
      end
      if (s1done[g]) begin
        act_done[g].push_back(done_t'{cyc, 1, s1q[g], terr[g]});
        busy[g] = 1'b0;
      end
      if (terr[g]) terr_cnt[g]++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Serve requests one bus transaction at a time: a request is seen
  // the cycle after its start, a start while pending is dropped, and
  // after each done the bus is free again one cycle later.
  task automatic model(input int g, input int t0);
    bit            pend [2];
    req_t          cur [2];
    int            t, idx, gr, s, d, l;
    bit            to;
    logic [DW-1:0] qv;
    pend[0] = 0;
    pend[1] = 0;
    t   = t0;
    idx = 0;
    forever begin
      while (idx < plan.size() && plan[idx].cyc < t) begin
        if (!pend[plan[idx].port]) begin
          pend[plan[idx].port] = 1;
          cur[plan[idx].port]  = plan[idx];
        end
        idx++;
      end
      if (!pend[0] && !pend[1]) begin
        if (idx >= plan.size()) break;
        t = plan[idx].cyc + 1;
        continue;
      end
      if (pend[0] && pend[1]) gr = (g == 1) ? 0 : 1 - mlast[g];
      else gr = pend[0] ? 0 : 1;
      s  = t + 1;
      l  = lat_of(cur[gr].addr);
      to = (l > TMO);
      d  = s + (to ? TMO : l) + 1;
      qv = to ? 32'hDEADBEEF : rd_of(cur[gr].addr);
      exp_iss[g].push_back(
        iss_t'{s, cur[gr].addr, cur[gr].data, cur[gr].we});
      exp_done[g].push_back(done_t'{d, gr, qv, to});
      if (to) exp_terr[g]++;
      while (idx < plan.size() && plan[idx].cyc <= d) begin
        if (!pend[plan[idx].port]) begin
          pend[plan[idx].port] = 1;
          cur[plan[idx].port]  = plan[idx];
        end
        idx++;
      end
      pend[gr]       = 0;
      mlast[g]       = gr;
      mq_last[g][gr] = qv;
      t              = d + 1;
      if (d > endc) endc = d;
    end
  endtask

  task automatic drive_cycle();
    s0_start = 1'b0;
    s1_start = 1'b0;
    s0_addr  = 27'($urandom);
    s1_addr  = 27'($urandom);
    s0_data  = $urandom;
    s1_data  = $urandom;
    s0_we    = 1'($urandom);
    s1_we    = 1'($urandom);
    foreach (plan[i]) begin
      if (plan[i].cyc == cyc) begin
        if (plan[i].port == 0) begin
          s0_start = 1'b1;
          s0_addr  = plan[i].addr;
          s0_data  = plan[i].data;
          s0_we    = plan[i].we;
        end else begin
          s1_start = 1'b1;
          s1_addr  = plan[i].addr;
          s1_data  = plan[i].data;
          s1_we    = plan[i].we;
        end
      end
    end
  endtask

  task automatic clear_all();
    for (int g = 0; g < 2; g++) begin
      exp_iss[g].delete();
      act_iss[g].delete();
      exp_done[g].delete();
      act_done[g].delete();
      exp_terr[g] = 0;
      terr_cnt[g] = 0;
      stab_err[g] = 0;
    end
    plan.delete();
  endtask

  task automatic compare(input string ph);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("%s.d%0d.n_issue", ph, g),
          64'(act_iss[g].size()), 64'(exp_iss[g].size()));
      for (int i = 0; i < exp_iss[g].size() && i < act_iss[g].size(); i++) begin
        chk($sformatf("%s.d%0d.iss%0d_cyc", ph, g, i),
            64'(act_iss[g][i].cyc), 64'(exp_iss[g][i].cyc));
        chk($sformatf("%s.d%0d.iss%0d_bus", ph, g, i),
            64'({act_iss[g][i].addr, act_iss[g][i].data, act_iss[g][i].we}),
            64'({exp_iss[g][i].addr, exp_iss[g][i].data, exp_iss[g][i].we}));
      end
      chk($sformatf("%s.d%0d.n_done", ph, g),
          64'(act_done[g].size()), 64'(exp_done[g].size()));
      for (int i = 0; i < exp_done[g].size() && i < act_done[g].size(); i++) begin
        chk($sformatf("%s.d%0d.done%0d_cyc", ph, g, i),
            64'(act_done[g][i].cyc), 64'(exp_done[g][i].cyc));
        chk($sformatf("%s.d%0d.done%0d_port", ph, g, i),
            64'(act_done[g][i].port), 64'(exp_done[g][i].port));
        chk($sformatf("%s.d%0d.done%0d_q", ph, g, i),
            64'(act_done[g][i].q), 64'(exp_done[g][i].q));
        chk($sformatf("%s.d%0d.done%0d_terr", ph, g, i),
            64'(act_done[g][i].terr), 64'(exp_done[g][i].terr));
      end
      chk($sformatf("%s.d%0d.terr_pulses", ph, g),
          64'(terr_cnt[g]), 64'(exp_terr[g]));
      chk($sformatf("%s.d%0d.bus_stable", ph, g), 64'(stab_err[g]), 64'(0));
      for (int p = 0; p < 2; p++)
        chk($sformatf("%s.d%0d.s%0d_q_hold", ph, g, p),
            64'(sq_of(g, p)), 64'(mq_last[g][p]));
    end
    clear_all();
  endtask

  task automatic run_plan(input string ph);
    int t0;
    t0   = cyc;
    endc = t0;
    model(0, t0);
    model(1, t0);
    endc += 6;
    while (cyc < endc) begin
      @(posedge clk);
      #1;
      drive_cycle();
    end
    @(posedge clk);
    #1;
    s0_start = 1'b0;
    s1_start = 1'b0;
    compare(ph);
  endtask

  task automatic rst_check(input string ph);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("%s.d%0d.q_zero", ph, g),
          64'({s0q[g], s1q[g]}), 64'(0));
      chk($sformatf("%s.d%0d.out_zero", ph, g),
          {maddr[g], mdata[g], mwe[g], mstart[g], terr[g],
           s0done[g], s1done[g]}, 64'(0));
    end
  endtask

  task automatic add_req(input int c, input int p, input logic [AW-1:0] a);
    plan.push_back(req_t'{c, p, a, $urandom, 1'($urandom)});
  endtask

  task automatic gen_random(input int span, input int pct);
    int base;
    base = cyc;
    for (int o = 2; o < span; o++)
      for (int p = 0; p < 2; p++)
        if ($urandom_range(99) < pct)
          add_req(base + o, p, {1'b0, 26'($urandom)});
  endtask

  initial begin
    int            base;
    logic [AW-1:0] a;
    for (int g = 0; g < 2; g++)
      for (int p = 0; p < 2; p++) mq_last[g][p] = '0;
    #1 nreset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_check("reset");
    nreset = 1'b1;

    // simultaneous starts, two rounds
    base = cyc;
    add_req(base + 2, 0, {1'b0, 26'($urandom)});
    add_req(base + 2, 1, {1'b0, 26'($urandom)});
    add_req(base + 40, 0, {1'b0, 26'($urandom)});
    add_req(base + 40, 1, {1'b0, 26'($urandom)});
    run_plan("tie");

    // single read with 3-cycle memory latency
    base = cyc;
    add_req(base + 2, 0, 27'h100);
    run_plan("single");

    // DMA in flight, CPU arrives in WAIT; extra DMA starts ignored
    base = cyc;
    a = {1'b0, 26'($urandom)};
    add_req(base + 2, 1, a);
    add_req(base + 6, 0, {1'b0, 26'($urandom)});
    add_req(base + 7, 1, {1'b0, 26'($urandom)});
    add_req(base + 5 + lat_of(a), 1, {1'b0, 26'($urandom)});
    run_plan("inflight");

    // no reply: forced completion, late m_done lands in IDLE
    base = cyc;
    add_req(base + 2, 0, {1'b1, 26'($urandom)});
    run_plan("timeout");

    for (int r = 0; r < 3; r++) begin
      gen_random(60, 12);
      run_plan($sformatf("rand%0d", r));
    end

    // reset while waiting on memory
    base = cyc;
    a = {1'b0, 23'($urandom), 3'b111};
    while (cyc < base + 7) begin
      @(posedge clk);
      #1;
      s0_start = (cyc == base + 2);
      s0_addr  = a;
    end
    nreset = 1'b0;
    #1;
    rst_check("rst_mid");
    repeat (2) @(posedge clk);
    #1;
    nreset = 1'b1;
    mlast  = '{1, 1};
    for (int g = 0; g < 2; g++)
      for (int p = 0; p < 2; p++) mq_last[g][p] = '0;
    repeat (16) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rst_mid.d%0d.n_issue", g),
          64'(act_iss[g].size()), 64'(1));
      chk($sformatf("rst_mid.d%0d.no_done", g),
          64'(act_done[g].size()), 64'(0));
      chk($sformatf("rst_mid.d%0d.no_terr", g), 64'(terr_cnt[g]), 64'(0));
    end
    clear_all();

    base = cyc;
    add_req(base + 2, 0, {1'b0, 26'($urandom)});
    run_plan("post_rst");

    gen_random(60, 15);
    run_plan("rand_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
